win_mul_seq: RTL and testbench

- Parametrised multi-cycle shift-add multiplier for the Winograd LeNet datapath. Generalises the fixed 8-bit sign-magnitude multiplier.
- Features: configurable operand width, configurable bits retired per cycle, per-operation signed/unsigned mode, valid/ready handshakes on input and output, and a synchronous flush.
- Sits between the transform stages and the accumulators. Several instances may share one issue port.

---
 rtl/win_mul_pkg.sv | 32 +++
 rtl/win_mul_signmag.sv | 22 ++
 rtl/win_mul_seq.sv | 155 +++++++++++++++
 tb/tb_win_mul_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/win_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   win_mul_state_e : FSM state encoding (IDLE, PREP, CALC, FIX, DONE)
//   clog2()         : constant function used to size the step counter
//   bpc_legal()     : constant function used for the elaboration-time
//                     check that BPC divides WIDTH
package win_mul_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } win_mul_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic bit bpc_legal(input int width, input int bpc);
        return (bpc >= 1) && (bpc <= width) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/win_mul_signmag.sv
// Combinational sign/magnitude split for one operand.
//   signed_en : 1 = treat x as two's complement, 0 = unsigned
//   x         : operand
//   mag       : |x| as an unsigned WIDTH-bit value (x itself when unsigned)
//   sgn       : 1 when x is a negative two's-complement value
// The most negative value negates to itself, which read as unsigned is
// exactly 2^(WIDTH-1), so no extra bit is needed.
module win_mul_signmag #(
    parameter int WIDTH = 8
) (
    input  logic             signed_en,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] mag,
    output logic             sgn
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign sgn = signed_en & x[WIDTH-1];
    assign mag = sgn ? ((~x) + ONE) : x;

endmodule

// File: rtl/win_mul_seq.sv
// Multi-cycle shift-add multiplier, BPC multiplier bits retired per cycle.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   flush               : synchronous abort, forces IDLE on the next edge
//   in_valid/in_ready   : operand handshake (in_signed, in_a, in_b)
//   out_valid/out_ready : product handshake (out_p, 2*WIDTH bits)
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid and ready are both 1. The producer holds its payload stable
// while valid=1 and ready=0; valid never depends on ready. in_ready is 1
// only in IDLE; out_valid is 1 only in DONE, where out_p is held.
//
// Flow: IDLE -> PREP (magnitudes, sign) -> CALC (N=WIDTH/BPC steps)
//       -> FIX (re-apply sign) -> DONE. The FSM state is kept in state_q.
module win_mul_seq
    import win_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? clog2(N) : 1;
    localparam logic [CW-1:0]        CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [2*WIDTH-1:0]   ACC_ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};

    if (!bpc_legal(WIDTH, BPC)) begin : g_bad_bpc
        $error("win_mul_seq: BPC must divide WIDTH");
    end

    win_mul_state_e state_q, state_d;

    logic                 armed_q;    // keeps in_ready low until the first edge after reset
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 signed_q;
    logic [2*WIDTH-1:0]   mcand_sh_q; // multiplicand, pre-shifted to the current bit position
    logic [WIDTH-1:0]     mplier_q;   // multiplier, consumed LSB first
    logic                 neg_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   out_p_q;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 sgn_a, sgn_b;
    logic [2*WIDTH-1:0]   pp;
    logic                 accept;

    win_mul_signmag #(.WIDTH(WIDTH)) u_sm_a (
        .signed_en (signed_q),
        .x         (a_q),
        .mag       (mag_a),
        .sgn       (sgn_a)
    );

    win_mul_signmag #(.WIDTH(WIDTH)) u_sm_b (
        .signed_en (signed_q),
        .x         (b_q),
        .mag       (mag_b),
        .sgn       (sgn_b)
    );

    // Sum of the partial products for the BPC multiplier bits of this step.
    always_comb begin
        pp = '0;
        for (int j = 0; j < BPC; j++) begin
            if (mplier_q[j]) begin
                pp = pp + (mcand_sh_q << j);
            end
        end
    end

    always_comb begin
        in_ready  = armed_q && (state_q == IDLE);
        out_valid = (state_q == DONE);
        accept    = in_valid && in_ready && !flush;
        state_d   = state_q;
        case (state_q)
            IDLE:    if (in_valid && in_ready) state_d = PREP;
            PREP:    state_d = CALC;
            CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // flush overrides every transition, including an accept in IDLE
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            signed_q   <= 1'b0;
            mcand_sh_q <= '0;
            mplier_q   <= '0;
            neg_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_p_q    <= '0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        signed_q <= in_signed;
                    end
                end
                PREP: begin
                    mcand_sh_q <= {{WIDTH{1'b0}}, mag_a};
                    mplier_q   <= mag_b;
                    neg_q      <= sgn_a ^ sgn_b;
                    acc_q      <= '0;
                    cnt_q      <= '0;
                end
                CALC: begin
                    acc_q      <= acc_q + pp;
                    mcand_sh_q <= mcand_sh_q << BPC;
                    mplier_q   <= mplier_q >> BPC;
                    cnt_q      <= cnt_q + CNT_ONE;
                end
                FIX: begin
                    // negating a zero accumulator gives zero, so 0 * -x stays 0
                    out_p_q <= neg_q ? ((~acc_q) + ACC_ONE) : acc_q;
                end
                default: ;
            endcase
        end
    end

    assign out_p = out_p_q;

endmodule

// File: tb/tb_win_mul_seq.sv
// Directed bench for win_mul_seq: an 8-bit/BPC=1 instance for the protocol
// scenarios, and two 16-bit instances (BPC=4, BPC=16) fed the same ops for
// latency and product checks against a bench-side reference.
module tb_win_mul_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic        flush, in_valid, in_signed, out_ready;
    logic [7:0]  in_a, in_b;
    logic        in_ready, out_valid;
    logic [15:0] out_p;

    // 16-bit instances share operands
    logic        flush16, in_valid16, in_signed16, out_ready16;
    logic [15:0] in_a16, in_b16;
    logic        in_ready16_4, out_valid16_4, in_ready16_16, out_valid16_16;
    logic [31:0] out_p16_4, out_p16_16;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    win_mul_seq #(.WIDTH(8), .BPC(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
    );

    win_mul_seq #(.WIDTH(16), .BPC(4)) u_dut16_4 (
        .clk(clk), .rst_n(rst_n), .flush(flush16),
        .in_valid(in_valid16), .in_ready(in_ready16_4), .in_signed(in_signed16),
        .in_a(in_a16), .in_b(in_b16),
        .out_valid(out_valid16_4), .out_ready(out_ready16), .out_p(out_p16_4)
    );

    win_mul_seq #(.WIDTH(16), .BPC(16)) u_dut16_16 (
        .clk(clk), .rst_n(rst_n), .flush(flush16),
        .in_valid(in_valid16), .in_ready(in_ready16_16), .in_signed(in_signed16),
        .in_a(in_a16), .in_b(in_b16),
        .out_valid(out_valid16_16), .out_ready(out_ready16), .out_p(out_p16_16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ref16(input logic sgn, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa, sb;
        if (sgn) begin
            sa = {{16{a[15]}}, a};
            sb = {{16{b[15]}}, b};
            return sa * sb;
        end
        return {16'b0, a} * {16'b0, b};
    endfunction

    // Issue one op to the 8-bit instance, expect the product after 10 edges.
    // If out_ready is high the drain to IDLE is checked as well.
    task automatic issue8(input string tag, input logic sgn, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp_v);
        int lat;
        logic [15:0] e;
        exp_q.push_back(exp_v);
        in_valid  = 1'b1;
        in_signed = sgn;
        in_a      = a;
        in_b      = b;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        check({tag, "_busy"}, 64'(in_ready), 64'd0);
        // operand changes after the accept edge must not matter
        in_a      = 8'($urandom_range(0, 255));
        in_b      = 8'($urandom_range(0, 255));
        in_signed = 1'($urandom_range(0, 1));
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        e = exp_q.pop_front();
        check({tag, "_lat"}, 64'(lat), 64'd10);
        check({tag, "_p"}, 64'(out_p), 64'(e));
        if (out_ready) begin
            @(posedge clk); #1;
            check({tag, "_drain"}, 64'({out_valid, in_ready}), 64'b01);
            check({tag, "_keep"}, 64'(out_p), 64'(e));
        end
    endtask

    // n cycles with no product expected on the 8-bit instance
    task automatic expect_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    task automatic issue16(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp_v);
        int lat4, lat16;
        logic [31:0] p4, p16;
        for (int c = 0; c < 20 && !(in_ready16_4 && in_ready16_16); c++) begin
            @(posedge clk); #1;
        end
        in_valid16  = 1'b1;
        in_signed16 = sgn;
        in_a16      = a;
        in_b16      = b;
        @(posedge clk); #1;
        in_valid16  = 1'b0;
        in_a16      = 16'($urandom_range(0, 65535));
        in_b16      = 16'($urandom_range(0, 65535));
        lat4 = 0; lat16 = 0; p4 = '0; p16 = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (lat4 == 0 && out_valid16_4) begin lat4 = c; p4 = out_p16_4; end
            if (lat16 == 0 && out_valid16_16) begin lat16 = c; p16 = out_p16_16; end
            if (lat4 != 0 && lat16 != 0) break;
        end
        check("w16_bpc4_lat", 64'(lat4), 64'd6);
        check("w16_bpc4_p", 64'(p4), 64'(exp_v));
        check("w16_bpc16_lat", 64'(lat16), 64'd3);
        check("w16_bpc16_p", 64'(p16), 64'(exp_v));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic sg;
        logic [15:0] ra, rb;

        flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0;
        flush16 = 1'b0; in_valid16 = 1'b0; in_signed16 = 1'b0; out_ready16 = 1'b1;
        in_a16 = '0; in_b16 = '0;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_p", 64'(out_p), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready_pre_edge", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("rel_ready", 64'(in_ready), 64'd1);

        // basic and corner products
        issue8("s_m3x7",      1'b1, 8'hFD, 8'h07, 16'hFFEB);
        issue8("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
        issue8("s_m128x127",  1'b1, 8'h80, 8'h7F, 16'hC080);
        issue8("u_255x255",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
        issue8("s_0xm5",      1'b1, 8'h00, 8'hFB, 16'h0000);
        issue8("u_253x7",     1'b0, 8'hFD, 8'h07, 16'h06EB);
        issue8("u_128x255",   1'b0, 8'h80, 8'hFF, 16'h7F80);
        issue8("s_m1xm1",     1'b1, 8'hFF, 8'hFF, 16'h0001);
        issue8("s_m1x1",      1'b1, 8'hFF, 8'h01, 16'hFFFF);

        // backpressure
        out_ready = 1'b0;
        issue8("bp", 1'b1, 8'h0C, 8'hFE, 16'hFFE8);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("bp_hold", 64'({out_valid, in_ready, out_p}), 64'({1'b1, 1'b0, 16'hFFE8}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 64'({out_valid, in_ready}), 64'b01);
        issue8("bp_next", 1'b0, 8'd5, 8'd6, 16'd30);

        // flush in the 4th CALC cycle
        in_valid = 1'b1; in_signed = 1'b0; in_a = 8'd200; in_b = 8'd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_calc_state", 64'({out_valid, in_ready}), 64'b01);
        expect_quiet("flush_calc_quiet", 15);
        issue8("after_flush_calc", 1'b0, 8'd5, 8'd6, 16'd30);

        // flush while a product waits in DONE
        out_ready = 1'b0;
        issue8("pre_flush_done", 1'b0, 8'd9, 8'd9, 16'd81);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_done_state", 64'({out_valid, in_ready}), 64'b01);
        out_ready = 1'b1;
        expect_quiet("flush_done_quiet", 12);
        issue8("after_flush_done", 1'b0, 8'd5, 8'd6, 16'd30);

        // flush together with a handshake: the op is dropped
        in_valid = 1'b1; flush = 1'b1; in_a = 8'd3; in_b = 8'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_ready", 64'(in_ready), 64'd1);
        expect_quiet("flush_accept_quiet", 15);

        // reset mid-operation
        in_valid = 1'b1; in_signed = 1'b0; in_a = 8'd7; in_b = 8'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_state", 64'({out_valid, in_ready, out_p}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 64'(in_ready), 64'd1);
        expect_quiet("midrst_quiet", 15);
        issue8("after_midrst", 1'b1, 8'hF6, 8'h0A, 16'hFF9C);

        // 16-bit instances, directed
        issue16(1'b1, 16'h8000, 16'h8000, 32'h40000000);
        issue16(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000);
        issue16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        issue16(1'b1, 16'h0000, 16'hFFFB, 32'h00000000);
        issue16(1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB);
        issue16(1'b0, 16'h1234, 16'h0100, 32'h00123400);
        issue16(1'b1, 16'h1234, 16'hFFFF, 32'hFFFFEDCC);
        issue16(1'b0, 16'hABCD, 16'h0003, 32'h00020367);

        // 16-bit instances, random pairs against the reference
        for (int i = 0; i < 200; i++) begin
            sg = 1'(i & 1);
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            issue16(sg, ra, rb, ref16(sg, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
